// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the MUL AB / DIV AB sequencer: op codes, state
// encoding, PSW bit positions and the PSW rebuild helper.
package muldiv_seq_pkg;

  localparam logic mul_ab = 1'b0;
  localparam logic div_ab = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int psw_cy = 7;
  localparam int psw_ov = 2;
  localparam int psw_p  = 0;

  // Carry is always cleared, OV comes from the operation, parity follows new A.
  function automatic logic [7:0] make_psw(input logic [7:0] psw,
                                          input logic       ov,
                                          input logic [7:0] acc);
    logic [7:0] r;
    r         = psw;
    r[psw_cy] = 1'b0;
    r[psw_ov] = ov;
    r[psw_p]  = ^acc;
    return r;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for MUL, restoring subtract for DIV.
module muldiv_step
  import muldiv_seq_pkg::*;
(
  input  logic        op_i,
  input  logic [15:0] acc_i,
  input  logic [7:0]  qm_i,
  input  logic [7:0]  opnd_i,
  output logic [15:0] acc_o,
  output logic [7:0]  qm_o
);

  logic [8:0] sum;
  logic [8:0] shRem;
  logic       ge;
  logic [7:0] remSub;

  // The shifted remainder never exceeds 9 bits, and when it is >= divisor the
  // difference always fits in 8 bits, so an 8-bit subtract is sufficient.
  always_comb begin
    sum    = {1'b0, acc_i[15:8]} + {1'b0, opnd_i};
    shRem  = acc_i[15:7];
    ge     = shRem >= {1'b0, opnd_i};
    remSub = acc_i[14:7] - opnd_i;
    acc_o  = acc_i;
    qm_o   = qm_i;
    if (op_i == mul_ab) begin
      acc_o = qm_i[0] ? {sum, acc_i[7:1]} : {1'b0, acc_i[15:1]};
      qm_o  = {1'b0, qm_i[7:1]};
    end else if (ge) begin
      acc_o = {remSub, acc_i[6:0], 1'b0};
      qm_o  = {qm_i[6:0], 1'b1};
    end else begin
      acc_o = {acc_i[14:0], 1'b0};
      qm_o  = {qm_i[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle sequencer for 8051 MUL AB / DIV AB: eight iterations, then a
// one-cycle done pulse with the new A, B and PSW held until the next result.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter bit ZERO_FAST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       op,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  input  logic [7:0] psw_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] a_out,
  output logic [7:0] b_out,
  output logic [7:0] psw_out
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  qm_q, qm_d;
  logic [7:0]  opnd_q, opnd_d;
  logic [7:0]  aLat_q, aLat_d;
  logic [7:0]  psw_q, psw_d;
  logic [7:0]  aOut_q, aOut_d;
  logic [7:0]  bOut_q, bOut_d;
  logic [7:0]  pswOut_q, pswOut_d;
  logic [15:0] stepAcc;
  logic [7:0]  stepQm;

  muldiv_step u_step (
    .op_i   (state_q == ST_DIV),
    .acc_i  (acc_q),
    .qm_i   (qm_q),
    .opnd_i (opnd_q),
    .acc_o  (stepAcc),
    .qm_o   (stepQm)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      qm_q     <= '0;
      opnd_q   <= '0;
      aLat_q   <= '0;
      psw_q    <= '0;
      aOut_q   <= '0;
      bOut_q   <= '0;
      pswOut_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      qm_q     <= qm_d;
      opnd_q   <= opnd_d;
      aLat_q   <= aLat_d;
      psw_q    <= psw_d;
      aOut_q   <= aOut_d;
      bOut_q   <= bOut_d;
      pswOut_q <= pswOut_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    qm_d     = qm_q;
    opnd_d   = opnd_q;
    aLat_d   = aLat_q;
    psw_d    = psw_q;
    aOut_d   = aOut_q;
    bOut_d   = bOut_q;
    pswOut_d = pswOut_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          cnt_d  = '0;
          aLat_d = a_in;
          psw_d  = psw_in;
          if (op == mul_ab) begin
            state_d = ST_MUL;
            acc_d   = '0;
            qm_d    = b_in;
            opnd_d  = a_in;
          end else begin
            acc_d  = {8'h00, a_in};
            qm_d   = '0;
            opnd_d = b_in;
            if (ZERO_FAST && (b_in == 8'h00)) begin
              state_d  = ST_DONE;
              aOut_d   = a_in;
              bOut_d   = 8'h00;
              pswOut_d = make_psw(psw_in, 1'b1, a_in);
            end else begin
              state_d = ST_DIV;
            end
          end
        end
      end
      default: begin
        cnt_d = cnt_q + 3'd1;
        acc_d = stepAcc;
        qm_d  = stepQm;
        if (cnt_q == 3'd7) begin
          state_d = ST_DONE;
          if (state_q == ST_MUL) begin
            aOut_d   = stepAcc[7:0];
            bOut_d   = stepAcc[15:8];
            pswOut_d = make_psw(psw_q, |stepAcc[15:8], stepAcc[7:0]);
          end else if (opnd_q == 8'h00) begin
            // Full-length divide by zero iterates on garbage; the defined result overrides it.
            aOut_d   = aLat_q;
            bOut_d   = 8'h00;
            pswOut_d = make_psw(psw_q, 1'b1, aLat_q);
          end else begin
            aOut_d   = stepQm;
            bOut_d   = stepAcc[15:8];
            pswOut_d = make_psw(psw_q, 1'b0, stepQm);
          end
        end
      end
    endcase
  end

  assign busy    = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign done    = (state_q == ST_DONE);
  assign a_out   = aOut_q;
  assign b_out   = bOut_q;
  assign psw_out = pswOut_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: drives a fast-zero and a full-length
// instance with identical stimulus and checks both against an arithmetic model.
module tb_muldiv_seq;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] psw;
    int         acceptEdge;
    int         doneEdge;
    bit         iterates;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       op;
  logic [7:0] aIn;
  logic [7:0] bIn;
  logic [7:0] pswIn;
  logic       busyO [2];
  logic       doneO [2];
  logic [7:0] aOutO [2];
  logic [7:0] bOutO [2];
  logic [7:0] pswOutO [2];

  exp_t       sb [2][$];
  int         freeAt [2];
  logic [7:0] lastA [2];
  logic [7:0] lastB [2];
  logic [7:0] lastP [2];
  int         edges = 0;
  logic       rstAtEdge = 1'b0;
  bit         monEn = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  muldiv_seq #(.ZERO_FAST(1'b1)) dutFast (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a_in(aIn), .b_in(bIn), .psw_in(pswIn),
    .busy(busyO[0]), .done(doneO[0]),
    .a_out(aOutO[0]), .b_out(bOutO[0]), .psw_out(pswOutO[0])
  );

  muldiv_seq #(.ZERO_FAST(1'b0)) dutFull (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a_in(aIn), .b_in(bIn), .psw_in(pswIn),
    .busy(busyO[1]), .done(doneO[1]),
    .a_out(aOutO[1]), .b_out(bOutO[1]), .psw_out(pswOutO[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    edges     <= edges + 1;
    rstAtEdge <= rst;
  end

  // Reference: plain 8051 arithmetic on the operands.
  function automatic exp_t refModel(input logic o, input logic [7:0] a,
                                    input logic [7:0] b, input logic [7:0] p);
    exp_t e;
    int   prod;
    logic ov;
    if (o == 1'b0) begin
      prod = int'(a) * int'(b);
      e.a  = 8'(prod % 256);
      e.b  = 8'(prod / 256);
      ov   = (prod > 255);
    end else if (b == 8'h00) begin
      e.a = a;
      e.b = 8'h00;
      ov  = 1'b1;
    end else begin
      e.a = 8'(int'(a) / int'(b));
      e.b = 8'(int'(a) % int'(b));
      ov  = 1'b0;
    end
    e.psw      = p;
    e.psw[7]   = 1'b0;
    e.psw[2]   = ov;
    e.psw[0]   = ^e.a;
    e.acceptEdge = 0;
    e.doneEdge   = 0;
    e.iterates   = 1'b1;
    return e;
  endfunction

  task automatic checkOutput(input string name, input int k,
                             input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s dut%0d edge %0d: got %0h, expected %0h",
               name, k, edges, act, expv);
    end
  endtask

  // Drives one clock of inputs and records which instances will accept a start.
  task automatic applyStimulus(input logic st, input logic rs, input logic o,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] p);
    int   acc;
    exp_t e;
    @(posedge clk);
    #2;
    start = st; rst = rs; op = o; aIn = a; bIn = b; pswIn = p;
    acc = edges + 1;
    if (rs) begin
      freeAt[0] = 0;
      freeAt[1] = 0;
    end else if (st) begin
      for (int k = 0; k < 2; k++) begin
        if (acc >= freeAt[k]) begin
          e = refModel(o, a, b, p);
          e.iterates   = !((k == 0) && o && (b == 8'h00));
          e.acceptEdge = acc;
          e.doneEdge   = acc + (e.iterates ? 8 : 0);
          sb[k].push_back(e);
          freeAt[k] = e.doneEdge + 1;
        end
      end
    end
  endtask

  task automatic applyIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  always @(negedge clk) begin
    if (monEn) begin
      for (int k = 0; k < 2; k++) begin
        logic expBusy;
        exp_t f;
        if (rstAtEdge) begin
          while (sb[k].size() > 0 && sb[k][0].acceptEdge <= edges) sb[k].delete(0);
          lastA[k] = 8'h00;
          lastB[k] = 8'h00;
          lastP[k] = 8'h00;
        end
        expBusy = 1'b0;
        for (int i = 0; i < sb[k].size(); i++)
          if (sb[k][i].iterates && edges >= sb[k][i].acceptEdge &&
              edges <= sb[k][i].acceptEdge + 7)
            expBusy = 1'b1;
        checkOutput("busy", k, busyO[k], expBusy);
        if (sb[k].size() > 0 && sb[k][0].doneEdge <= edges) begin
          f = sb[k].pop_front();
          checkOutput("done", k, doneO[k], 1);
          lastA[k] = f.a;
          lastB[k] = f.b;
          lastP[k] = f.psw;
        end else begin
          checkOutput("done", k, doneO[k], 0);
        end
        checkOutput("a_out", k, aOutO[k], lastA[k]);
        checkOutput("b_out", k, bOutO[k], lastB[k]);
        checkOutput("psw_out", k, pswOutO[k], lastP[k]);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; aIn = '0; bIn = '0; pswIn = '0;
    freeAt[0] = 0;
    freeAt[1] = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    monEn = 1'b1;
    applyIdle(2);

    applyStimulus(1'b1, 1'b0, 1'b0, 8'h50, 8'hA0, 8'h00);
    applyIdle(10);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h0C, 8'h10, 8'hFF);
    applyIdle(10);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hFB, 8'h12, 8'h00);
    applyIdle(10);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h37, 8'h00, 8'h00);
    applyIdle(10);

    // Starts during iterations must be ignored.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h5A, 8'h33, 8'h18);
    applyIdle(2);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF, 8'h01, 8'h00);
    applyIdle(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h10, 8'h03, 8'h00);
    applyIdle(8);

    // Start held through DONE gives a back-to-back second operation.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'hE7, 8'h9B, 8'h66);
    applyIdle(12);

    // Reset mid-operation, then a clean restart.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hC8, 8'h07, 8'h22);
    applyIdle(3);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h00);
    applyIdle(10);

    // Reset wins over a simultaneous start.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h12, 8'h34, 8'h00);
    applyIdle(3);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] rb;
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      applyStimulus(($urandom_range(0, 3) == 0), 1'b0, 1'($urandom),
                    8'($urandom), rb, 8'($urandom));
    end
    applyIdle(12);

    for (int k = 0; k < 2; k++) checkOutput("drain", k, sb[k].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
